// File: rtl/mc_stream_pkg.sv
// Shared constants, arbitration mode type and the round-robin pick helper
// for the multi-channel stream arbiter.
package mc_stream_pkg;

    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CHW        = $clog2(NUM_CH);
    localparam int unsigned LW         = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned MAX_CH     = 32;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    // First requester found scanning upward from ptr, wrapping modulo n.
    // Returns ptr when nothing requests; callers mask that case.
    function automatic int unsigned rr_pick(input logic [MAX_CH-1:0] req,
                                            input int unsigned ptr,
                                            input int unsigned n);
        int unsigned idx;
        int unsigned off;
        rr_pick = ptr;
        for (int unsigned k = 0; k < MAX_CH; k++) begin
            off = MAX_CH - 1 - k;
            if (off < n) begin
                idx = (ptr + off) % n;
                if (req[idx[4:0]]) begin
                    rr_pick = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, occupancy level and synchronous flush.
module sync_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           push,
    input  logic [DW-1:0]                  wdata,
    input  logic                           pop,
    output logic [DW-1:0]                  rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Power-of-two depth makes the pointer difference exactly LVL_W bits wide.
    assign level   = LVL_W'(wr_ptr_q - rd_ptr_q);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/mc_stream_arbiter.sv
// N-channel stream merger: per-channel FIFOs arbitrated (round-robin or fixed
// priority) into one registered, channel-tagged valid/ready output.
module mc_stream_arbiter
    import mc_stream_pkg::*;
#(
    parameter int unsigned N_CH  = NUM_CH,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                mode_i,
    input  logic                                flush_i,
    input  logic [N_CH-1:0]                     in_valid_i,
    output logic [N_CH-1:0]                     in_ready_o,
    input  logic [N_CH*DW-1:0]                  in_data_i,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [DW-1:0]                       out_data_o,
    output logic [$clog2(N_CH)-1:0]             out_ch_o,
    output logic [N_CH*$clog2(DEPTH+1)-1:0]     level_o
);

    localparam int unsigned CH_W  = $clog2(N_CH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [N_CH-1:0] push, pop, full, empty;
    logic [DW-1:0]   rdata [N_CH];

    logic [MAX_CH-1:0] req_ext;
    logic              load;
    arb_mode_e         mode;
    logic [CH_W-1:0]   grant;

    logic              out_valid_q, out_valid_d;
    logic [DW-1:0]     out_data_q, out_data_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        // Ready is purely registered state plus flush, so downstream ready
        // never reaches the input handshake combinationally.
        assign in_ready_o[c] = !full[c] && !flush_i;
        assign push[c]       = in_valid_i[c] && in_ready_o[c];

        sync_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush_i),
            .push  (push[c]),
            .wdata (in_data_i[c*DW +: DW]),
            .pop   (pop[c]),
            .rdata (rdata[c]),
            .full  (full[c]),
            .empty (empty[c]),
            .level (level_o[c*LVL_W +: LVL_W])
        );
    end

    always_comb begin
        req_ext           = '0;
        req_ext[N_CH-1:0] = ~empty;
        mode              = arb_mode_e'(mode_i);
        load              = (!out_valid_q || out_ready_i) && (|(~empty)) && !flush_i;

        if (mode == ARB_FIXED) begin
            grant = CH_W'(rr_pick(req_ext, 0, N_CH));
        end else begin
            grant = CH_W'(rr_pick(req_ext, 32'(rr_ptr_q), N_CH));
        end

        pop = '0;
        if (load) pop[grant] = 1'b1;

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;

        if (flush_i) begin
            out_valid_d = 1'b0;
            rr_ptr_d    = '0;
        end else if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = rdata[grant];
            out_ch_d    = grant;
            if (mode == ARB_RR) begin
                rr_ptr_d = CH_W'((32'(grant) + 32'd1) % N_CH);
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_ch_o    = out_ch_q;

endmodule

// File: tb/tb_mc_stream_arbiter.sv
// Scoreboard bench for mc_stream_arbiter: queue-based reference model,
// decoupled output monitor, directed scenarios and a randomized phase.
module tb_mc_stream_arbiter;

    localparam int N_CH  = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 mode_i;
    logic                 flush_i;
    logic [N_CH-1:0]      in_valid_i;
    logic [N_CH-1:0]      in_ready_o;
    logic [N_CH*DW-1:0]   in_data_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [DW-1:0]        out_data_o;
    logic [1:0]           out_ch_o;
    logic [N_CH*LW-1:0]   level_o;

    mc_stream_arbiter #(
        .N_CH  (N_CH),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode_i      (mode_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_ch_o    (out_ch_o),
        .level_o     (level_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [7:0]  d;
    } item_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mq [N_CH][$];
    bit          m_hold;
    int          m_ptr;
    item_t       exp_q [$];
    int          ch_log [$];
    logic [7:0]  data_log [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < N_CH; c++) mq[c].delete();
        m_hold = 1'b0;
        m_ptr  = 0;
        exp_q.delete();
    endtask

    // Reference model: FIFOs as queues, output register as one held item.
    always @(posedge clk or negedge rst_n) begin : model
        bit acc [N_CH];
        int g;
        int c;
        if (!rst_n) begin
            model_clear();
        end else if (flush_i) begin
            model_clear();
        end else begin
            for (int i = 0; i < N_CH; i++) acc[i] = in_valid_i[i] && (mq[i].size() < DEPTH);
            if (!m_hold || out_ready_i) begin
                g = -1;
                for (int k = 0; k < N_CH; k++) begin
                    c = mode_i ? k : (m_ptr + k) % N_CH;
                    if (g < 0 && mq[c].size() > 0) g = c;
                end
                if (g >= 0) begin
                    exp_q.push_back('{ch: g, d: mq[g].pop_front()});
                    m_hold = 1'b1;
                    if (!mode_i) m_ptr = (g + 1) % N_CH;
                end else begin
                    m_hold = 1'b0;
                end
            end
            for (int i = 0; i < N_CH; i++) if (acc[i]) mq[i].push_back(in_data_i[i*DW +: DW]);
        end
    end

    // Monitor: compares DUT outputs with the model away from the active edge.
    always @(negedge clk) begin : monitor
        logic [N_CH*LW-1:0] exp_lvl;
        logic [N_CH-1:0]    exp_rdy;
        item_t              it;
        for (int c = 0; c < N_CH; c++) begin
            exp_lvl[c*LW +: LW] = LW'(mq[c].size());
            exp_rdy[c]          = (mq[c].size() < DEPTH) && !flush_i;
        end
        chk("out_valid", 32'(out_valid_o), 32'(m_hold));
        chk("level", 32'(level_o), 32'(exp_lvl));
        chk("in_ready", 32'(in_ready_o), 32'(exp_rdy));
        if (out_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 32'(out_valid_o), 32'd0);
            end else begin
                it = exp_q[0];
                chk("out_data", 32'(out_data_o), 32'(it.d));
                chk("out_ch", 32'(out_ch_o), 32'(it.ch));
                if (out_ready_i) begin
                    void'(exp_q.pop_front());
                    ch_log.push_back(int'(out_ch_o));
                    data_log.push_back(out_data_o);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input int c, input logic [7:0] d, input int budget, output bit ok);
        bit rdy;
        ok = 1'b0;
        in_valid_i[c]          = 1'b1;
        in_data_i[c*DW +: DW]  = d;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            rdy = in_ready_o[c];
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid_i[c] = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 300 && !idle; i++) begin
            @(posedge clk);
            #2;
            idle = !m_hold && exp_q.size() == 0;
            for (int c = 0; c < N_CH; c++) if (mq[c].size() != 0) idle = 1'b0;
        end
        chk("drain_timeout", 32'(idle), 32'd1);
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    task automatic preload_all();
        in_valid_i = '1;
        for (int c = 0; c < N_CH; c++) in_data_i[c*DW +: DW] = 8'hC0 + 8'(c);
        tick();
        for (int c = 0; c < N_CH; c++) in_data_i[c*DW +: DW] = 8'hD0 + 8'(c);
        tick();
        in_valid_i = '0;
    endtask

    initial begin
        int exp_rr [8];
        int exp_fx [8];
        bit ok;
        exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};
        exp_fx = '{0, 0, 1, 1, 2, 2, 3, 3};

        rst_n       = 1'b0;
        mode_i      = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = '0;
        in_data_i   = '0;
        out_ready_i = 1'b0;

        // Reset and idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready_o), 32'hF);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_out_data", 32'(out_data_o), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Single channel with latency check
        out_ready_i = 1'b1;
        ch_log.delete();
        data_log.delete();
        in_valid_i[2]        = 1'b1;
        in_data_i[2*DW +: DW] = 8'hA1;
        tick();
        in_data_i[2*DW +: DW] = 8'hA2;
        @(negedge clk);
        chk("lat_not_yet", 32'(out_valid_o), 32'd0);
        tick();
        in_valid_i[2] = 1'b0;
        @(negedge clk);
        chk("lat_valid", 32'(out_valid_o), 32'd1);
        chk("lat_data", 32'(out_data_o), 32'hA1);
        chk("lat_ch", 32'(out_ch_o), 32'd2);
        wait_idle();
        chk("single_cnt", 32'(data_log.size()), 32'd2);
        if (data_log.size() == 2) begin
            chk("single_w0", 32'(data_log[0]), 32'hA1);
            chk("single_w1", 32'(data_log[1]), 32'hA2);
        end

        // Round-robin
        do_flush();
        mode_i      = 1'b0;
        out_ready_i = 1'b0;
        preload_all();
        ch_log.delete();
        data_log.delete();
        out_ready_i = 1'b1;
        wait_idle();
        chk("rr_cnt", 32'(ch_log.size()), 32'd8);
        if (ch_log.size() == 8)
            for (int i = 0; i < 8; i++) chk($sformatf("rr_ch%0d", i), 32'(ch_log[i]), 32'(exp_rr[i]));

        // Fixed priority
        do_flush();
        mode_i      = 1'b1;
        out_ready_i = 1'b0;
        preload_all();
        ch_log.delete();
        data_log.delete();
        out_ready_i = 1'b1;
        wait_idle();
        chk("fx_cnt", 32'(ch_log.size()), 32'd8);
        if (ch_log.size() == 8)
            for (int i = 0; i < 8; i++) chk($sformatf("fx_ch%0d", i), 32'(ch_log[i]), 32'(exp_fx[i]));
        mode_i = 1'b0;

        // Backpressure and full
        do_flush();
        out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_one(1, 8'h10 + 8'(i), 10, ok);
            chk($sformatf("bp_accept%0d", i), 32'(ok), 32'd1);
        end
        @(negedge clk);
        chk("bp_level", 32'(level_o[1*LW +: LW]), 32'd4);
        chk("bp_ready", 32'(in_ready_o[1]), 32'd0);
        chk("bp_hold", 32'(out_data_o), 32'h10);
        push_one(1, 8'h99, 3, ok);
        chk("bp_reject", 32'(ok), 32'd0);
        ch_log.delete();
        data_log.delete();
        out_ready_i = 1'b1;
        wait_idle();
        chk("bp_cnt", 32'(data_log.size()), 32'd5);
        if (data_log.size() == 5)
            for (int i = 0; i < 5; i++) chk($sformatf("bp_w%0d", i), 32'(data_log[i]), 32'h10 + 32'(i));

        // Flush with buffered data
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) push_one(3, 8'h30 + 8'(i), 10, ok);
        @(negedge clk);
        chk("fl_pre_level", 32'(level_o[3*LW +: LW]), 32'd3);
        chk("fl_pre_valid", 32'(out_valid_o), 32'd1);
        tick();
        flush_i              = 1'b1;
        in_valid_i[0]        = 1'b1;
        in_data_i[0 +: DW]   = 8'h55;
        @(negedge clk);
        chk("fl_in_ready", 32'(in_ready_o), 32'd0);
        tick();
        flush_i       = 1'b0;
        in_valid_i[0] = 1'b0;
        @(negedge clk);
        chk("fl_valid", 32'(out_valid_o), 32'd0);
        chk("fl_level", 32'(level_o), 32'd0);
        tick();

        // Randomized traffic with a mid-stream asynchronous reset
        for (int cyc = 0; cyc < 2000; cyc++) begin
            tick();
            in_valid_i  = N_CH'($urandom);
            in_data_i   = $urandom;
            out_ready_i = ($urandom_range(9) < 7);
            flush_i     = ($urandom_range(96) == 0);
            if ($urandom_range(49) == 0) mode_i = ~mode_i;
            if (cyc == 1000) begin
                in_valid_i = '1;
                out_ready_i = 1'b0;
                flush_i = 1'b0;
                repeat (3) tick();
                #1 rst_n = 1'b0;
                #1;
                chk("arst_valid", 32'(out_valid_o), 32'd0);
                chk("arst_level", 32'(level_o), 32'd0);
                chk("arst_ready", 32'(in_ready_o), 32'hF);
                @(posedge clk);
                #2 rst_n = 1'b1;
            end
        end
        tick();
        in_valid_i  = '0;
        flush_i     = 1'b0;
        out_ready_i = 1'b1;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_stream_arbiter.md
# mc_stream_arbiter

Parametrised multi-channel stream merger: N_CH independent valid/ready input channels, each buffered in its own FIFO, arbitrated onto one registered valid/ready output tagged with the source channel. This is the next-generation design under test for the team's UVM environment. It generalises the single-stream item path to N channels, selectable arbitration mode, occupancy reporting and synchronous flush. One input agent drives each channel; the output agent and scoreboard check order and tags.

## Interface
- N_CH, 4, number of input channels (≥2)
- DW, 8, data width in bits
- DEPTH, 4, per-channel FIFO depth (power of 2, ≥2)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- mode_i  in  1  0 = round-robin, 1 = fixed priority (channel 0 highest)
- flush_i  in  1  synchronous clear of all buffered data
- in_valid_i  in  N_CH  per-channel valid
- in_ready_o  out  N_CH  per-channel ready
- in_data_i  in  N_CH*DW  channel c at bits [c*DW +: DW]
- out_valid_o  out  1  output word valid
- out_ready_i  in  1  downstream ready
- out_data_o  out  DW  output word
- out_ch_o  out  CHW  source channel of out_data_o; CHW = $clog2(N_CH)
- level_o  out  N_CH*LW  per-channel FIFO occupancy; LW = $clog2(DEPTH+1)

## Operation
- Reset values: out_valid_o=0, out_data_o=0, out_ch_o=0, level_o all 0, in_ready_o all 1, RR pointer=0.
- Push on channel c when in_valid_i[c] && in_ready_o[c].
- in_ready_o[c] = !full[c] && !flush_i. It depends only on registered state and flush_i, never on in_valid_i.
- A full FIFO does not accept a push in the same cycle as its pop.
- Output stage is one holding register. It loads when (!out_valid_o || out_ready_i) and at least one FIFO is non-empty; the granted FIFO pops in that cycle.
- When no FIFO is non-empty and the register drains, out_valid_o falls.
- Round-robin: the search starts at RR pointer p, ascending mod N_CH. After a grant to channel g, p ← (g+1) mod N_CH.
- Fixed priority: the lowest-index non-empty channel wins. The RR pointer is not updated.
- mode_i is sampled at each arbitration. A change applies to the next grant; in-flight data is unaffected.
- flush_i high at an edge: all FIFOs empty, levels 0, out_valid_o=0, RR pointer=0. Pushes and pops in that cycle are discarded; flush has priority over everything.
- level_o[c] updates at every push or pop: +1 push only, −1 pop only, unchanged for both or neither. Range 0..DEPTH.
- Per-channel order is preserved. Cross-channel order is defined only by the arbitration rules.
- Reset asserted mid-transfer: all state returns to reset values immediately (asynchronous); buffered data is lost.

## Timing
- Latency: a word accepted at edge k reaches the FIFO at k, loads into the output register at k+1, and shows out_valid_o=1 in the cycle after k+1. Minimum accept-to-valid is 1 cycle; the register is loaded at the second edge.
- Throughput: 1 word/cycle aggregate while out_ready_i=1 and any FIFO is non-empty.
- Output hold: while out_valid_o && !out_ready_i, out_data_o and out_ch_o are stable, and no FIFO pops.
- The input handshake has no combinational path from out_ready_i to in_ready_o.

## Structure
- Package mc_stream_pkg holds:
  - localparams CHW and LW (functions of N_CH and DEPTH)
  - enum arb_mode_e {ARB_RR, ARB_FIXED}
  - helper function rr_pick(req, ptr) returning the granted index
- Sub-module sync_fifo (DW, DEPTH): pointers with an extra wrap bit, plus full, empty, level and a flush input. It is instantiated N_CH times via generate.
- The top level contains the arbiter, the RR pointer and the output register.

## Test plan
- Reset, then idle: in_ready_o=4'b1111, out_valid_o=0, level_o all 0; de-asserting rst_n mid-stream clears out_valid_o the same cycle.
- Single channel: ch2 pushes 0xA1, 0xA2 with out_ready_i=1 → outputs 0xA1 then 0xA2, out_ch_o=2, first out_valid_o in the cycle after the second edge.
- Round-robin: all 4 channels pre-loaded with 2 words each (0xC0+c, 0xD0+c), out_ready_i=1 → out_ch_o sequence 0,1,2,3,0,1,2,3.
- Fixed priority: same preload with mode_i=1 → out_ch_o sequence 0,0,1,1,2,2,3,3.
- Backpressure/full: out_ready_i=0, push 5 words on ch1 with DEPTH=4:
  - in_ready_o[1]=0 once level_o[1]=4
  - out_data_o holds the first word, with 4 more buffered
  - releasing out_ready_i returns all 5 words in order
- Flush: 3 words buffered on ch3 with out_valid_o=1, pulse flush_i → next cycle out_valid_o=0, level_o[3]=0; a push presented in the flush cycle is not accepted.
